// File: rtl/mem_nrmw.sv
// mem_nrmw: parametrised multi-port register-file memory.
//
// Storage is p_num_entries words of p_bit_width bits. There are p_num_wr
// independent write ports and p_num_rd independent read ports. Reads are
// either combinational (p_rd_latency=0) or pass through one output register
// per port (p_rd_latency=1).
//
// Ports (all port arrays packed, port 0 in the lowest slice):
//   clk         in   clock
//   reset       in   synchronous active-high reset; loads the reset image
//   write_en    in   [p_num_wr]               per-port write enable
//   write_addr  in   [p_num_wr*p_addr_width]  per-port write address
//   write_data  in   [p_num_wr*p_bit_width]   per-port write data
//   read_en     in   [p_num_rd]               per-port read enable
//   read_addr   in   [p_num_rd*p_addr_width]  per-port read address
//   read_data   out  [p_num_rd*p_bit_width]   per-port read data
//
// Behaviour summary:
//   - Several writes to one address in a cycle: highest-indexed port wins.
//   - Out-of-range writes are dropped; out-of-range reads return 0.
//   - Disabled reads return 0 (no hold of the previous value).
//   - With p_bypass=1 a read sees the winning same-cycle write data.
//   - Reset image: 0 (p_init_mode=0) or mem[i]=i (p_init_mode=1).
//   - There is no valid/ready handshake: every enabled access is accepted
//     in the cycle it is presented.

module mem_nrmw #(
  parameter int p_num_entries = 8,
  parameter int p_bit_width   = 32,
  parameter int p_num_rd      = 2,
  parameter int p_num_wr      = 2,
  parameter int p_rd_latency  = 0,
  parameter int p_bypass      = 1,
  parameter int p_init_mode   = 1,
  // Guarded so a single-entry memory still gets a 1-bit address.
  parameter int p_addr_width  = (p_num_entries > 1) ? $clog2(p_num_entries) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_num_wr-1:0]              write_en,
  input  logic [p_num_wr*p_addr_width-1:0] write_addr,
  input  logic [p_num_wr*p_bit_width-1:0]  write_data,
  input  logic [p_num_rd-1:0]              read_en,
  input  logic [p_num_rd*p_addr_width-1:0] read_addr,
  output logic [p_num_rd*p_bit_width-1:0]  read_data
);

  localparam logic [31:0] lp_entries = 32'(p_num_entries);

  logic [p_bit_width-1:0]          mem [p_num_entries];
  logic [p_num_wr-1:0]             wr_valid;
  logic [p_num_rd*p_bit_width-1:0] rd_val;
  logic [p_bit_width-1:0]          rd_word;

  function automatic logic in_range(input logic [p_addr_width-1:0] a);
    return 32'(a) < lp_entries;
  endfunction

  // A write is effective only when enabled, in range and not in a reset
  // cycle. The same qualifier drives both storage and the bypass path so
  // the forwarded value always matches what will be stored.
  always_comb begin
    wr_valid = '0;
    for (int w = 0; w < p_num_wr; w++) begin
      wr_valid[w] = write_en[w] && !reset &&
                    in_range(write_addr[w*p_addr_width +: p_addr_width]);
    end
  end

  // Ports are visited in ascending order; the last non-blocking assignment
  // to an address takes effect, giving the highest-indexed port priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) begin
        mem[i] <= (p_init_mode == 1) ? p_bit_width'(i) : '0;
      end
    end else begin
      for (int w = 0; w < p_num_wr; w++) begin
        if (wr_valid[w]) begin
          mem[write_addr[w*p_addr_width +: p_addr_width]] <=
            write_data[w*p_bit_width +: p_bit_width];
        end
      end
    end
  end

  // Effective read value per port. The bypass scan also runs in ascending
  // port order so the forwarded word is the same one that wins the write.
  always_comb begin
    rd_val  = '0;
    rd_word = '0;
    for (int r = 0; r < p_num_rd; r++) begin
      rd_word = '0;
      if (read_en[r] && !reset &&
          in_range(read_addr[r*p_addr_width +: p_addr_width])) begin
        rd_word = mem[read_addr[r*p_addr_width +: p_addr_width]];
        if (p_bypass == 1) begin
          for (int w = 0; w < p_num_wr; w++) begin
            if (wr_valid[w] &&
                write_addr[w*p_addr_width +: p_addr_width] ==
                read_addr[r*p_addr_width +: p_addr_width]) begin
              rd_word = write_data[w*p_bit_width +: p_bit_width];
            end
          end
        end
      end
      rd_val[r*p_bit_width +: p_bit_width] = rd_word;
    end
  end

  generate
    if (p_rd_latency == 0) begin : g_comb_read
      assign read_data = rd_val;
    end else begin : g_reg_read
      // The register sits after the bypass mux, so no combinational path
      // exists from the write ports to read_data in this mode.
      logic [p_num_rd*p_bit_width-1:0] read_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          read_q <= '0;
        end else begin
          read_q <= rd_val;
        end
      end
      assign read_data = read_q;
    end
  endgenerate

endmodule
